// File: rtl/svo_stream_checker_pkg.sv
// Shared types and constants for the SVO stream checker: FSM encoding, CRC-32 constants
// and the stall LFSR step function.
package svo_stream_checker_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } chk_state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Fibonacci LFSR, taps 16,14,13,11 (shift right, feedback into bit 15).
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/svo_chk_crc32.sv
// Combinational CRC-32 step over one W-bit word, non-reflected polynomial,
// data consumed LSB first.
module svo_chk_crc32
  import svo_stream_checker_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [31:0]  crc_in,
  input  logic [W-1:0] data,
  output logic [31:0]  crc_out
);

  logic [31:0] c;
  logic        fb;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it holding its old value and no latch is inferred.
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 0; i < W; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/svo_stream_checker.sv
// Self-checking SVO pixel sink: drives tready (always or with LFSR stalls), checks
// frame geometry, counts frames/errors and reports a CRC-32 per complete frame.
module svo_stream_checker
  import svo_stream_checker_pkg::*;
#(
  parameter int          SVO_HOR_PIXELS     = 640,
  parameter int          SVO_VER_PIXELS     = 480,
  parameter int          SVO_BITS_PER_PIXEL = 18,
  parameter int          USER_BITS          = 1,
  parameter int          READY_MODE         = 0,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1,
  parameter logic [15:0] STALL_MASK         = 16'h0003
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          clear,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [USER_BITS-1:0]          in_axis_tuser,
  output logic                          locked,
  output logic                          frame_done,
  output logic [31:0]                   frame_crc,
  output logic [15:0]                   frame_count,
  output logic                          err_short,
  output logic                          err_long,
  output logic [15:0]                   err_count
);

  localparam int WORD_W = SVO_BITS_PER_PIXEL + USER_BITS - 1;
  localparam int X_W    = (SVO_HOR_PIXELS > 1) ? $clog2(SVO_HOR_PIXELS) : 1;
  localparam int Y_W    = $clog2(SVO_VER_PIXELS + 1);

  chk_state_t        state, state_next;
  logic [15:0]       lfsr;
  logic [X_W-1:0]    x, x_cur;
  logic [Y_W-1:0]    y, y_cur;
  logic [31:0]       crc, crc_base, crc_next;
  logic [WORD_W-1:0] word;
  logic              seen_frame;
  logic              beat, sof, accept, line_end, complete;
  logic              ev_short, ev_long;

  // Upper tuser bits ride along with the pixel into the CRC.
  generate
    if (USER_BITS > 1) begin : g_word_user
      assign word = {in_axis_tuser[USER_BITS-1:1], in_axis_tdata};
    end else begin : g_word_plain
      assign word = in_axis_tdata;
    end
  endgenerate

  assign beat     = in_axis_tvalid && in_axis_tready;
  assign sof      = in_axis_tuser[0];
  assign accept   = beat && (sof || state == IN_FRAME);
  // A SOF pixel always starts a fresh frame at (0,0) with a fresh CRC.
  assign x_cur    = sof ? '0 : x;
  assign y_cur    = sof ? '0 : y;
  assign crc_base = sof ? CRC32_INIT : crc;
  assign line_end = (x_cur == X_W'(SVO_HOR_PIXELS - 1));
  assign complete = accept && line_end && (y_cur == Y_W'(SVO_VER_PIXELS - 1));
  assign ev_short = beat && sof && state == IN_FRAME;
  assign ev_long  = beat && !sof && state == WAIT_SOF && (seen_frame || frame_count != 16'd0);

  svo_chk_crc32 #(.W(WORD_W)) u_crc (
    .crc_in  (crc_base),
    .data    (word),
    .crc_out (crc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order in which always_ff blocks run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= WAIT_SOF;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = complete ? WAIT_SOF : IN_FRAME;
  end

  always_comb begin
    locked = (state == IN_FRAME);
  end

  // tready comes from the look-ahead LFSR value so it never depends on tvalid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr           <= LFSR_SEED;
      in_axis_tready <= 1'b0;
    end else begin
      lfsr           <= lfsr16_next(lfsr);
      in_axis_tready <= (READY_MODE == 0) ? 1'b1 : ~|(lfsr16_next(lfsr) & STALL_MASK);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      crc        <= CRC32_INIT;
      frame_crc  <= '0;
      frame_done <= 1'b0;
      seen_frame <= 1'b0;
    end else begin
      frame_done <= complete;
      if (complete) begin
        x          <= '0;
        y          <= '0;
        crc        <= CRC32_INIT;
        frame_crc  <= crc_next;
        seen_frame <= 1'b1;
      end else if (accept) begin
        crc <= crc_next;
        if (line_end) begin
          x <= '0;
          y <= y_cur + 1'b1;
        end else begin
          x <= x_cur + 1'b1;
          y <= y_cur;
        end
      end
    end
  end

  // clear takes priority over any same-cycle completion or error event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
      err_count   <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else if (clear) begin
      frame_count <= '0;
      err_count   <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      if (complete) frame_count <= frame_count + 16'd1;
      if (ev_short) err_short <= 1'b1;
      if (ev_long)  err_long  <= 1'b1;
      if ((ev_short || ev_long) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule
